// File: rtl/gimli_stream_buffer_out.sv
// Wide-to-narrow stream serialiser for Gimli state/tag output blocks.
// Little-endian word order; the final word carries the residual byte count.
module gimli_stream_buffer_out #(
    parameter int DIN_WIDTH       = 128,
    parameter int DIN_SIZE_WIDTH  = 4,
    parameter int DOUT_WIDTH      = 32,
    parameter int DOUT_SIZE_WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DIN_WIDTH-1:0]       din,
    input  logic [DIN_SIZE_WIDTH:0]    din_size,
    input  logic                       din_last,
    input  logic                       din_valid,
    output logic                       din_ready,
    output logic [DOUT_WIDTH-1:0]      dout,
    output logic [DOUT_SIZE_WIDTH:0]   dout_size,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic                       dout_last,
    output logic [DIN_SIZE_WIDTH:0]    size
);

    localparam int BYTES = 2 ** DOUT_SIZE_WIDTH;
    localparam int SW    = DIN_SIZE_WIDTH + 1;
    localparam int OSW   = DOUT_SIZE_WIDTH + 1;

    typedef enum logic {
        EMPTY,
        ACTIVE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [DIN_WIDTH-1:0] reg_buffer;
    logic [SW-1:0]        reg_size;
    logic                 reg_last;
    logic                 reg_active;
    logic                 fits;
    logic                 final_word;
    logic                 load;
    logic                 accept;

    assign reg_active = (state == ACTIVE);
    assign fits       = (reg_size <= SW'(BYTES));
    assign final_word = reg_active & fits;
    assign din_ready  = ~reg_active | (final_word & dout_ready);
    assign load       = din_valid & din_ready;
    assign accept     = reg_active & dout_ready;

    assign dout       = reg_buffer[DOUT_WIDTH-1:0];
    assign dout_size  = fits ? reg_size[OSW-1:0] : OSW'(BYTES);
    assign dout_valid = reg_active;
    assign dout_last  = reg_last & final_word;
    assign size       = reg_size;

    // An empty non-last block is swallowed without producing a word.
    always_comb begin
        state_next = state;
        if (load) begin
            state_next = ((din_size != '0) || din_last) ? ACTIVE : EMPTY;
        end else if (accept && fits) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_size <= '0;
            reg_last <= 1'b0;
        end else if (load) begin
            reg_buffer <= din;
            reg_size   <= din_size;
            reg_last   <= din_last;
        end else if (accept) begin
            if (fits) begin
                reg_size <= '0;
                reg_last <= 1'b0;
            end else begin
                reg_buffer <= reg_buffer >> DOUT_WIDTH;
                reg_size   <= reg_size - SW'(BYTES);
            end
        end
    end

endmodule

// File: tb/tb_gimli_stream_buffer_out.sv
// Directed bench for gimli_stream_buffer_out with an expected-word queue.
// A negedge monitor pops and checks each word the DUT hands over.
module tb_gimli_stream_buffer_out;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] din;
    logic [4:0]   din_size;
    logic         din_last;
    logic         din_valid;
    logic         din_ready;
    logic [31:0]  dout;
    logic [2:0]   dout_size;
    logic         dout_valid;
    logic         dout_ready;
    logic         dout_last;
    logic [4:0]   size;

    int errors = 0;
    int checks = 0;
    logic tog = 1'b0;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  s;
        logic        l;
        logic        f;
    } exp_t;

    exp_t q[$];

    gimli_stream_buffer_out dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_size   (din_size),
        .din_last   (din_last),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_size  (dout_size),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .size       (size)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mask_of(input logic [2:0] s);
        if (s >= 3'd4) return 32'hffff_ffff;
        return (32'd1 << (8 * s)) - 32'd1;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (dout_valid) begin
                checks++;
                assert (q.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_word dout=%h size=%0d expected none", dout, dout_size);
                end
                if (q.size() > 0) begin
                    checks++;
                    assert ((dout & mask_of(q[0].s)) === (q[0].d & mask_of(q[0].s))) else begin
                        errors++;
                        $error("FAIL dout got=%h exp=%h", dout, q[0].d);
                    end
                    checks++;
                    assert (dout_size === q[0].s) else begin
                        errors++;
                        $error("FAIL dout_size got=%0d exp=%0d", dout_size, q[0].s);
                    end
                    checks++;
                    assert (dout_last === q[0].l) else begin
                        errors++;
                        $error("FAIL dout_last got=%b exp=%b", dout_last, q[0].l);
                    end
                    checks++;
                    assert (din_ready === (q[0].f & dout_ready)) else begin
                        errors++;
                        $error("FAIL din_ready_busy got=%b exp=%b", din_ready, q[0].f & dout_ready);
                    end
                    if (dout_ready) void'(q.pop_front());
                end
            end else begin
                checks++;
                assert (din_ready === 1'b1 && dout_last === 1'b0) else begin
                    errors++;
                    $error("FAIL idle_outputs din_ready=%b dout_last=%b exp 1/0", din_ready, dout_last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (tog) dout_ready = ~dout_ready;
    endtask

    task automatic push_block(input logic [127:0] d, input int sz, input logic lst);
        int n;
        int rem;
        exp_t e;
        n = (sz == 0) ? (lst ? 1 : 0) : (sz + 3) / 4;
        rem = sz;
        for (int i = 0; i < n; i++) begin
            e.d = d[32*i +: 32];
            e.s = (rem >= 4) ? 3'd4 : 3'(rem);
            e.l = lst && (i == n - 1);
            e.f = (i == n - 1);
            rem = rem - 4;
            q.push_back(e);
        end
    endtask

    task automatic send(input logic [127:0] d, input int sz, input logic lst);
        int n;
        push_block(d, sz, lst);
        din = d;
        din_size = 5'(sz);
        din_last = lst;
        din_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!din_ready && n < 200) begin
            tick();
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < 200) else begin
            errors++;
            $error("FAIL send_timeout waited=%0d limit=200", n);
        end
        tick();
        din_valid = 1'b0;
    endtask

    task automatic drain(output int cyc);
        cyc = 0;
        while (q.size() != 0 && cyc < 200) begin
            tick();
            cyc++;
        end
        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL drain_timeout left=%0d exp=0", q.size());
        end
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        din = '0;
        din_size = 5'd16;
        din_last = 1'b0;
        din_valid = 1'b1;
        dout_ready = 1'b1;

        // 1: reset with din_valid high
        tick();
        tick();
        rst = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        checks++;
        assert (dout_valid === 1'b0 && size === 5'd0 && din_ready === 1'b1 && dout_size === 3'd0)
        else begin
            errors++;
            $error("FAIL reset valid=%b size=%0d rdy=%b dsz=%0d exp 0/0/1/0",
                   dout_valid, size, din_ready, dout_size);
        end
        tick();

        // 2: full block, four consecutive words
        send(128'h33333333_22222222_11111111_00000000, 16, 1'b0);
        checks++;
        assert (size === 5'd16) else begin
            errors++;
            $error("FAIL size_after_load got=%0d exp=16", size);
        end
        drain(cyc);
        checks++;
        assert (cyc == 4) else begin
            errors++;
            $error("FAIL full_block_cycles got=%0d exp=4", cyc);
        end
        tick();

        // 3: partial last block
        send(128'h0_0000beef_a5a5a5a5, 6, 1'b1);
        drain(cyc);
        checks++;
        assert (cyc == 2) else begin
            errors++;
            $error("FAIL partial_cycles got=%0d exp=2", cyc);
        end
        tick();
        tick();

        // 4: back-to-back full blocks
        send(128'h03030303_02020202_01010101_00000000, 16, 1'b0);
        send(128'h77777777_66666666_55555555_44444444, 16, 1'b1);
        drain(cyc);
        checks++;
        assert (cyc == 4) else begin
            errors++;
            $error("FAIL b2b_tail_cycles got=%0d exp=4", cyc);
        end
        tick();

        // 5: alternating backpressure
        tog = 1'b1;
        send(128'hdddddddd_cccccccc_bbbbbbbb_aaaaaaaa, 16, 1'b0);
        drain(cyc);
        tog = 1'b0;
        dout_ready = 1'b1;
        tick();

        // 6a: empty non-last block is swallowed
        send(128'hffff, 0, 1'b0);
        tick();
        tick();
        checks++;
        assert (dout_valid === 1'b0) else begin
            errors++;
            $error("FAIL empty_block_swallowed valid=%b exp=0", dout_valid);
        end

        // 6b: empty last block gives one zero-size last word
        send(128'h0, 0, 1'b1);
        drain(cyc);
        tick();

        // 6c: reset after first word of four
        send(128'h13131313_12121212_11111111_10101010, 16, 1'b0);
        tick();
        rst = 1'b1;
        q.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        assert (dout_valid === 1'b0 && size === 5'd0) else begin
            errors++;
            $error("FAIL mid_reset valid=%b size=%0d exp 0/0", dout_valid, size);
        end
        tick();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
